multicycle_control_unit: RTL and testbench

Moore-style finite state machine that sequences the shared multicycle datapath of the RV32I core: instruction fetch, decode, address and ALU computation, memory access and register write-back. The immediate generator, ALU, register file and unified memory are shared across cycles of one instruction. This block drives every mux select and write enable for them, one state per datapath cycle. Covered opcodes: lw `0000011`, sw `0100011`, R-type `0110011`, I-type ALU `0010011`, beq `1100011`.

---
 rtl/multicycle_control_unit_pkg.sv | 66 ++++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit_opcode_classifier.sv | 21 ++
 rtl/multicycle_control_unit.sv | 135 +++++++++++++
 tb/tb_multicycle_control_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control path: state codes,
// covered opcodes, datapath select values and the instruction class type.
package riscv_ctrl_pkg;

    // Binary state encoding, 4 bits wide.
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_EXEC_I   = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXEC_R   = ST_EXEC_R,
        S_EXEC_I   = ST_EXEC_I,
        S_ALUWB    = ST_ALUWB,
        S_BRANCH   = ST_BRANCH
    } state_t;

    // Covered opcodes (instruction[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU A operand select.
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // ALU operation.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Write-back result select.
    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_MEM_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit and the shared datapath: status inputs
// from the datapath and every select / enable the control unit drives.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       illegal_instr;
    logic       instr_done;

    // Control unit side.
    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal_instr,
               instr_done
    );

    // Datapath side.
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal_instr,
               instr_done
    );
endinterface

// File: rtl/multicycle_control_unit_opcode_classifier.sv
// Maps a 7-bit opcode onto the instruction class the sequencer branches on.
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    // Pure lookup; anything outside the covered set is illegal.
    always_comb begin
        case (opcode)
            OP_LOAD:   instr_class = CLS_LOAD;
            OP_STORE:  instr_class = CLS_STORE;
            OP_RTYPE:  instr_class = CLS_RTYPE;
            OP_ITYPE:  instr_class = CLS_ITYPE;
            OP_BRANCH: instr_class = CLS_BRANCH;
            default:   instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the shared multicycle RV32I datapath. One state per
// datapath cycle; outputs decode from the state, with mem_ready qualifying
// FETCH/MEMWRITE and zero qualifying the branch PC load.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);

    state_t       state;
    state_t       state_next;
    instr_class_t instr_class;
    logic         pc_update;
    logic         branch;

    opcode_classifier u_classifier (
        .opcode      (bus.opcode),
        .instr_class (instr_class)
    );

    // State register; reset drops straight to FETCH without a clock edge.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state selection; opcode only matters in DECODE and MEMADR.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (instr_class)
                    CLS_LOAD, CLS_STORE: state_next = S_MEMADR;
                    CLS_RTYPE:           state_next = S_EXEC_R;
                    CLS_ITYPE:           state_next = S_EXEC_I;
                    CLS_BRANCH:          state_next = S_BRANCH;
                    default:             state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (instr_class == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode; everything not named for a state stays 0.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_update         = 1'b0;
        branch            = 1'b0;
        bus.ir_write      = 1'b0;
        bus.adr_src       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RS2;
        bus.alu_op        = ALUOP_ADD;
        bus.result_src    = RES_ALU_OUT;
        bus.illegal_instr = 1'b0;
        bus.instr_done    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU_RESULT;
                // Reset holds the IR and PC even if memory reports ready.
                bus.ir_write   = bus.mem_ready & ~reset;
                pc_update      = bus.mem_ready & ~reset;
            end
            S_DECODE: begin
                // Branch target = old PC + imm, parked in ALU-out.
                bus.alu_src_a     = SRCA_OLD_PC;
                bus.alu_src_b     = SRCB_IMM;
                bus.illegal_instr = (instr_class == CLS_ILLEGAL);
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.mem_read = 1'b1;
                bus.adr_src  = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = RES_MEM_DATA;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_write  = 1'b1;
                bus.adr_src    = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                bus.result_src = RES_ALU_OUT;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = SRCA_RS1;
                bus.alu_src_b  = SRCB_RS2;
                bus.alu_op     = ALUOP_SUB;
                bus.result_src = RES_ALU_OUT;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        bus.pc_write = pc_update | (branch & bus.zero);
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control unit. Each scenario walks an
// instruction cycle by cycle and compares the full output vector against
// hand-derived constants.
module tb_multicycle_control_unit;
    import riscv_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout:
    // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    //  alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, instr_done}
    localparam logic [15:0] V_FETCH_GO   = 16'b110100_00_10_00_10_00;
    localparam logic [15:0] V_FETCH_WAIT = 16'b000100_00_10_00_10_00;
    localparam logic [15:0] V_DECODE     = 16'b000000_01_01_00_00_00;
    localparam logic [15:0] V_DECODE_ILL = 16'b000000_01_01_00_00_10;
    localparam logic [15:0] V_MEMADR     = 16'b000000_10_01_00_00_00;
    localparam logic [15:0] V_MEMREAD    = 16'b001100_00_00_00_00_00;
    localparam logic [15:0] V_MEMWB      = 16'b000001_00_00_00_01_01;
    localparam logic [15:0] V_MEMWR_WAIT = 16'b001010_00_00_00_00_00;
    localparam logic [15:0] V_MEMWR_DONE = 16'b001010_00_00_00_00_01;
    localparam logic [15:0] V_EXEC_R     = 16'b000000_10_00_10_00_00;
    localparam logic [15:0] V_EXEC_I     = 16'b000000_10_01_10_00_00;
    localparam logic [15:0] V_ALUWB      = 16'b000001_00_00_00_00_01;
    localparam logic [15:0] V_BR_TAKEN   = 16'b100000_10_00_01_00_01;
    localparam logic [15:0] V_BR_NOT     = 16'b000000_10_00_01_00_01;

    function automatic logic [15:0] outputs_now();
        return {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.result_src, bus.illegal_instr, bus.instr_done};
    endfunction

    task automatic test_reset();
        logic [15:0] got;
        logic [15:0] exp_i [4];
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.opcode    = 7'b0000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            got = outputs_now();
            checks++;
            if (got !== V_FETCH_WAIT) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, got, V_FETCH_WAIT);
            end
        end
        // Release mid-low-phase; next rising edge fetches an I-type.
        reset      = 1'b0;
        bus.opcode = OP_ITYPE;
        exp_i = '{V_FETCH_GO, V_DECODE, V_EXEC_I, V_ALUWB};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_i[i]) begin
                errors++;
                $display("FAIL reset_release_itype cycle %0d: got %b expected %b", i, got, exp_i[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [15:0] got;
        logic [15:0] exp_v [5];
        exp_v = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
        bus.opcode = OP_LOAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_v[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_sw_stall();
        logic [15:0] got;
        logic [15:0] exp_v [6];
        logic        rdy   [6];
        exp_v = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMWR_WAIT, V_MEMWR_WAIT, V_MEMWR_DONE};
        rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.opcode = OP_STORE;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.mem_ready = rdy[i];
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_v[i]) begin
                errors++;
                $display("FAIL sw_stall cycle %0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic [15:0] got;
        logic [15:0] exp_v [6];
        logic        zer   [6];
        // zero toggles outside BRANCH to show only BRANCH reacts to it.
        exp_v = '{V_FETCH_GO, V_DECODE, V_BR_TAKEN, V_FETCH_GO, V_DECODE, V_BR_NOT};
        zer   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.opcode = OP_BRANCH;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            bus.zero      = zer[i];
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_v[i]) begin
                errors++;
                $display("FAIL beq cycle %0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [15:0] got;
        logic [15:0] exp_v [4];
        exp_v = '{V_FETCH_GO, V_DECODE, V_EXEC_R, V_ALUWB};
        bus.opcode = OP_RTYPE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_v[i]) begin
                errors++;
                $display("FAIL rtype cycle %0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] got;
        logic [15:0] exp_v [4];
        logic        rdy   [4];
        logic [6:0]  opc   [4];
        // Back in FETCH with memory stalled; opcode churn there is ignored.
        exp_v = '{V_FETCH_GO, V_DECODE_ILL, V_FETCH_WAIT, V_FETCH_WAIT};
        rdy   = '{1'b1, 1'b1, 1'b0, 1'b0};
        opc   = '{7'b1111111, 7'b1111111, OP_LOAD, OP_BRANCH};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_ready = rdy[i];
            bus.opcode    = opc[i];
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_v[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        logic [15:0] exp_v [4];
        logic        rdy   [4];
        exp_v = '{V_FETCH_GO, V_DECODE, V_MEMADR, V_MEMREAD};
        rdy   = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.opcode = OP_LOAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_ready = rdy[i];
            #1;
            got = outputs_now();
            checks++;
            if (got !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_mid lw cycle %0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
        // Still in the low phase of MEMREAD: assert reset with no edge.
        #1;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        got = outputs_now();
        checks++;
        if (got !== V_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_mid async: got %b expected %b", got, V_FETCH_WAIT);
        end
        @(negedge clk);
        #1;
        got = outputs_now();
        checks++;
        if (got !== V_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_mid held: got %b expected %b", got, V_FETCH_WAIT);
        end
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        got = outputs_now();
        checks++;
        if (got !== V_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_mid released: got %b expected %b", got, V_FETCH_WAIT);
        end
        @(negedge clk);
        #1;
        got = outputs_now();
        checks++;
        if (got !== V_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_mid no_memwb: got %b expected %b", got, V_FETCH_WAIT);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
